// File: rtl/sample_stream_pacer_pkg.sv
// Shared constants, FSM encoding and frame-geometry helper for the
// UART-stream sample pacer.
package sdr_stream_pkg;

    localparam int ACC_W      = 32;
    localparam int UNDERRUN_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_PLAY  = 2'd2
    } pacer_state_e;

    function automatic int frame_width(input int sample_bytes, input int channels);
        return 8 * sample_bytes * channels;
    endfunction

endpackage

// File: rtl/sample_stream_pacer_frame_fifo.sv
// Single-clock frame FIFO with registered read data, a level counter and
// registered full / programmable threshold flags.
module frame_fifo
    import sdr_stream_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 512,
    parameter int PFULL  = DEPTH - 8,
    parameter int PEMPTY = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic [LW-1:0]    level,
    output logic             full,
    output logic             prog_full,
    output logic             prog_empty
);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [LW-1:0]    level_r;
    logic [LW-1:0]    level_next_s;
    logic [WIDTH-1:0] rd_data_r;
    logic             full_r;
    logic             prog_full_r;
    logic             prog_empty_r;
    logic             wr_ok_s;
    logic             rd_ok_s;

    // Qualify requests against the registered occupancy.
    always_comb begin
        wr_ok_s = wr_en && !full_r;
        rd_ok_s = rd_en && (level_r != {LW{1'b0}});
    end

    // Next occupancy; a simultaneous push and pop leaves it unchanged.
    always_comb begin
        level_next_s = level_r;
        case ({wr_ok_s, rd_ok_s})
            2'b10:   level_next_s = level_r + 1'b1;
            2'b01:   level_next_s = level_r - 1'b1;
            default: level_next_s = level_r;
        endcase
    end

    // Storage array; RAM contents need no reset since reads are level-gated.
    always_ff @(posedge clk) begin
        if (wr_ok_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    // Pointers, read register, level and flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_r     <= {AW{1'b0}};
            rd_ptr_r     <= {AW{1'b0}};
            rd_data_r    <= {WIDTH{1'b0}};
            level_r      <= {LW{1'b0}};
            full_r       <= 1'b0;
            prog_full_r  <= 1'b0;
            prog_empty_r <= 1'b0;
        end else begin
            if (wr_ok_s) begin
                wr_ptr_r <= wr_ptr_r + 1'b1;
            end
            if (rd_ok_s) begin
                rd_ptr_r  <= rd_ptr_r + 1'b1;
                rd_data_r <= mem_r[rd_ptr_r];
            end
            level_r      <= level_next_s;
            full_r       <= (level_next_s == LW'(DEPTH));
            prog_full_r  <= (level_next_s >= LW'(PFULL));
            prog_empty_r <= (level_next_s <= LW'(PEMPTY));
        end
    end

    assign rd_data    = rd_data_r;
    assign level      = level_r;
    assign full       = full_r;
    assign prog_full  = prog_full_r;
    assign prog_empty = prog_empty_r;

endmodule

// File: rtl/sample_stream_pacer.sv
// Assembles UART bytes into multi-channel frames, buffers them and plays them
// out at a rate set by a 32-bit phase accumulator.
module sample_stream_pacer
    import sdr_stream_pkg::*;
#(
    parameter int SAMPLE_BYTES = 2,
    parameter int CHANNELS     = 1,
    parameter int DEPTH        = 512,
    parameter int START_LEVEL  = DEPTH / 4,
    parameter int PFULL        = DEPTH - 8,
    parameter int PEMPTY       = 8,
    localparam int SAMPLE_W    = 8 * SAMPLE_BYTES,
    localparam int FRAME_W     = frame_width(SAMPLE_BYTES, CHANNELS),
    localparam int LW          = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            rx_data,
    input  logic                  rbyte_ready,
    input  logic                  resync,
    input  logic                  en,
    input  logic [ACC_W-1:0]      code_clk_sample,
    output logic [FRAME_W-1:0]    out_data,
    output logic                  out_valid,
    output logic [LW-1:0]         level,
    output logic                  prog_full,
    output logic                  prog_empty,
    output logic                  playing,
    output logic                  overflow,
    output logic [UNDERRUN_W-1:0] underrun_cnt
);

    localparam int FRAME_BYTES = SAMPLE_BYTES * CHANNELS;
    localparam int CNT_W       = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1;

    logic [CNT_W-1:0]      byte_cnt_r;
    logic [CNT_W-1:0]      cnt_base_s;
    logic [CNT_W-1:0]      cnt_next_s;
    logic [FRAME_W-1:0]    frame_r;
    logic [FRAME_W-1:0]    frame_base_s;
    logic [FRAME_W-1:0]    frame_next_s;
    logic                  frame_done_s;
    logic                  wr_en_r;
    logic                  fifo_full_s;
    logic                  overflow_r;
    logic [ACC_W-1:0]      acc_r;
    logic [ACC_W:0]        acc_sum_s;
    logic                  tick_s;
    pacer_state_e          state_r;
    pacer_state_e          state_next_s;
    logic                  pop_s;
    logic                  underrun_s;
    logic                  out_valid_r;
    logic                  playing_r;
    logic [UNDERRUN_W-1:0] underrun_cnt_r;

    // Byte assembly: shift right so the first byte received ends in the LSBs;
    // resync restarts from an empty frame, and a byte arriving with it is byte 0.
    always_comb begin
        frame_base_s = resync ? {FRAME_W{1'b0}} : frame_r;
        cnt_base_s   = resync ? {CNT_W{1'b0}} : byte_cnt_r;
        frame_next_s = frame_base_s;
        cnt_next_s   = cnt_base_s;
        frame_done_s = 1'b0;
        if (rbyte_ready) begin
            frame_next_s                  = frame_base_s >> 4'd8;
            frame_next_s[FRAME_W-1 -: 8]  = rx_data;
            frame_done_s                  = (cnt_base_s == CNT_W'(FRAME_BYTES - 1));
            cnt_next_s                    = frame_done_s ? {CNT_W{1'b0}} : cnt_base_s + 1'b1;
        end else begin
            frame_next_s = frame_base_s;
            cnt_next_s   = cnt_base_s;
            frame_done_s = 1'b0;
        end
    end

    // Assembly state and the one-cycle-delayed write strobe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            byte_cnt_r <= {CNT_W{1'b0}};
            frame_r    <= {FRAME_W{1'b0}};
            wr_en_r    <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            byte_cnt_r <= cnt_next_s;
            frame_r    <= frame_next_s;
            wr_en_r    <= frame_done_s;
            overflow_r <= overflow_r | (wr_en_r & fifo_full_s);
        end
    end

    // Phase accumulator; the carry out of the top bit is the playback tick.
    always_comb begin
        acc_sum_s = {1'b0, acc_r} + {1'b0, code_clk_sample};
        if (en) begin
            tick_s = acc_sum_s[ACC_W];
        end else begin
            tick_s = 1'b0;
        end
    end

    // Accumulator register, parked at zero while playback is disabled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_r <= {ACC_W{1'b0}};
        end else if (en) begin
            acc_r <= acc_sum_s[ACC_W-1:0];
        end else begin
            acc_r <= {ACC_W{1'b0}};
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next state: disabling always returns to IDLE without touching the FIFO.
    always_comb begin
        state_next_s = state_r;
        if (!en) begin
            state_next_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE:  state_next_s = ST_PRIME;
                ST_PRIME: state_next_s = (level >= LW'(START_LEVEL)) ? ST_PLAY : ST_PRIME;
                ST_PLAY:  state_next_s = (tick_s && (level == {LW{1'b0}})) ? ST_PRIME : ST_PLAY;
                default:  state_next_s = ST_IDLE;
            endcase
        end
    end

    // FSM outputs: a tick in PLAY either pops a frame or records an underrun.
    always_comb begin
        pop_s      = 1'b0;
        underrun_s = 1'b0;
        if ((state_r == ST_PLAY) && tick_s) begin
            pop_s      = (level != {LW{1'b0}});
            underrun_s = (level == {LW{1'b0}});
        end else begin
            pop_s      = 1'b0;
            underrun_s = 1'b0;
        end
    end

    // Registered status outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_r    <= 1'b0;
            playing_r      <= 1'b0;
            underrun_cnt_r <= {UNDERRUN_W{1'b0}};
        end else begin
            out_valid_r <= pop_s;
            playing_r   <= (state_next_s == ST_PLAY);
            if (underrun_s && (underrun_cnt_r != {UNDERRUN_W{1'b1}})) begin
                underrun_cnt_r <= underrun_cnt_r + 1'b1;
            end
        end
    end

    frame_fifo #(
        .WIDTH  (FRAME_W),
        .DEPTH  (DEPTH),
        .PFULL  (PFULL),
        .PEMPTY (PEMPTY)
    ) u_frame_fifo (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en_r),
        .wr_data    (frame_r),
        .rd_en      (pop_s),
        .rd_data    (out_data),
        .level      (level),
        .full       (fifo_full_s),
        .prog_full  (prog_full),
        .prog_empty (prog_empty)
    );

    assign out_valid    = out_valid_r;
    assign playing      = playing_r;
    assign overflow     = overflow_r;
    assign underrun_cnt = underrun_cnt_r;

endmodule

// File: tb/tb_sample_stream_pacer.sv
// Scoreboard bench for sample_stream_pacer: frames are queued as they are sent
// and compared in order as out_valid pulses appear.
module tb_sample_stream_pacer;

    localparam int FW    = 32;
    localparam int LW    = 5;
    localparam int DEPTH = 16;

    logic          clk;
    logic          rst;
    logic [7:0]    rx_data;
    logic          rbyte_ready;
    logic          resync;
    logic          en;
    logic [31:0]   code_clk_sample;
    logic [FW-1:0] out_data;
    logic          out_valid;
    logic [LW-1:0] level;
    logic          prog_full;
    logic          prog_empty;
    logic          playing;
    logic          overflow;
    logic [15:0]   underrun_cnt;

    int            n_checks = 0;
    int            n_pass   = 0;
    int            cyc      = 0;
    int            pulses   = 0;
    int            last_cyc = 0;
    int            model_level = 0;
    int            gap_a [0:255];
    logic          prev_valid = 1'b0;
    logic [FW-1:0] sb [$];

    sample_stream_pacer #(
        .SAMPLE_BYTES (2),
        .CHANNELS     (2),
        .DEPTH        (DEPTH),
        .START_LEVEL  (4),
        .PFULL        (12),
        .PEMPTY       (2)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .rx_data         (rx_data),
        .rbyte_ready     (rbyte_ready),
        .resync          (resync),
        .en              (en),
        .code_clk_sample (code_clk_sample),
        .out_data        (out_data),
        .out_valid       (out_valid),
        .level           (level),
        .prog_full       (prog_full),
        .prog_empty      (prog_empty),
        .playing         (playing),
        .overflow        (overflow),
        .underrun_cnt    (underrun_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Output monitor: compares each pulse against the scoreboard head.
    initial begin
        logic [FW-1:0] exp_frame;
        forever begin
            @(negedge clk);
            if (rst && out_valid) begin
                check_eq("valid_width", prev_valid, 1'b0);
                if (sb.size() == 0) begin
                    check_eq("sb_nonempty", sb.size(), 1);
                end else begin
                    exp_frame = sb.pop_front();
                    check_eq("out_data", out_data, exp_frame);
                    model_level--;
                end
                gap_a[pulses] = cyc - last_cyc;
                last_cyc = cyc;
                pulses++;
            end
            prev_valid = rst && out_valid;
        end
    end

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic with_resync);
        rx_data     = b;
        rbyte_ready = 1'b1;
        resync      = with_resync;
        @(posedge clk);
        #1;
        rbyte_ready = 1'b0;
        resync      = 1'b0;
    endtask

    task automatic send_frame(input logic [FW-1:0] f);
        for (int i = 0; i < 4; i++) begin
            logic [7:0] b;
            b = f[8*i +: 8];
            send_byte(b, 1'b0);
        end
        if (model_level < DEPTH) begin
            sb.push_back(f);
            model_level++;
        end
    endtask

    task automatic wait_pulses(input int target, input int budget);
        int t;
        t = 0;
        while (pulses < target && t < budget) begin
            @(posedge clk);
            #1;
            t++;
        end
        check_eq("pulse_wait", pulses >= target, 1'b1);
    endtask

    initial begin
        int p0;
        rst = 1'b1;
        rx_data = 8'd0;
        rbyte_ready = 1'b0;
        resync = 1'b0;
        en = 1'b0;
        code_clk_sample = 32'h8000_0000;
        #1 rst = 1'b0;
        #1;
        check_eq("rst_out_data", out_data, 0);
        check_eq("rst_flags", {out_valid, playing, overflow, prog_full, prog_empty}, 5'b0);
        check_eq("rst_level", level, 0);
        check_eq("rst_underrun", underrun_cnt, 0);
        @(posedge clk);
        #1 rst = 1'b1;
        wait_cycles(2);
        check_eq("prog_empty_idle", prog_empty, 1'b1);

        // Priming and first playback burst.
        en = 1'b1;
        send_frame(32'h5678_1234);
        send_frame(32'hCAFE_0001);
        send_frame(32'h0BAD_F00D);
        wait_cycles(10);
        check_eq("prime_playing", playing, 1'b0);
        check_eq("prime_pulses", pulses, 0);
        check_eq("prime_level", level, 3);
        send_frame(32'h1357_9BDF);
        wait_cycles(4);
        check_eq("play_playing", playing, 1'b1);
        wait_pulses(4, 40);
        for (int j = 1; j < 4; j++) begin
            check_eq("max_rate_gap", gap_a[j], 2);
        end
        wait_cycles(6);
        check_eq("underrun_cnt1", underrun_cnt, 1);
        check_eq("underrun_prime", playing, 1'b0);
        check_eq("underrun_hold", out_data, 32'h1357_9BDF);
        check_eq("underrun_pulses", pulses, 4);

        // Overflow with playback disabled.
        en = 1'b0;
        wait_cycles(2);
        for (int i = 0; i < 16; i++) begin
            send_frame(32'hA000_0000 + 32'(i));
        end
        wait_cycles(3);
        check_eq("fill_level", level, 16);
        check_eq("fill_overflow", overflow, 1'b0);
        check_eq("fill_prog_full", prog_full, 1'b1);
        check_eq("fill_prog_empty", prog_empty, 1'b0);
        send_frame(32'hDEAD_BEEF);
        wait_cycles(3);
        check_eq("ovf_level", level, 16);
        check_eq("ovf_flag", overflow, 1'b1);
        en = 1'b1;
        wait_pulses(20, 100);
        wait_cycles(6);
        check_eq("drain_sb", sb.size(), 0);
        check_eq("drain_level", level, 0);
        check_eq("drain_prog_empty", prog_empty, 1'b1);
        check_eq("underrun_cnt2", underrun_cnt, 2);
        check_eq("ovf_sticky", overflow, 1'b1);

        // Resync handling, alone and together with a byte.
        en = 1'b0;
        wait_cycles(2);
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b0);
        resync = 1'b1;
        @(posedge clk);
        #1 resync = 1'b0;
        send_frame(32'h5678_1234);
        wait_cycles(3);
        check_eq("resync_level", level, 1);
        send_byte(8'hAA, 1'b0);
        send_byte(8'h34, 1'b1);
        send_byte(8'h12, 1'b0);
        send_byte(8'h78, 1'b0);
        send_byte(8'h56, 1'b0);
        sb.push_back(32'h5678_1234);
        model_level++;
        send_frame(32'h0F0E_0D0C);
        send_frame(32'hFFFF_0000);
        wait_cycles(3);
        check_eq("resync_level4", level, 4);

        // Zero code: playing but no ticks.
        code_clk_sample = 32'h0;
        en = 1'b1;
        wait_cycles(20);
        check_eq("zero_code_playing", playing, 1'b1);
        check_eq("zero_code_pulses", pulses, 20);
        code_clk_sample = 32'h8000_0000;
        wait_pulses(24, 40);
        wait_cycles(6);
        check_eq("underrun_cnt3", underrun_cnt, 3);

        // Asynchronous reset mid-playback.
        en = 1'b0;
        wait_cycles(2);
        for (int i = 0; i < 4; i++) begin
            send_frame(32'h4400_0000 + 32'(i));
        end
        en = 1'b1;
        wait_pulses(25, 40);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check_eq("midrst_out", {out_data, out_valid}, 33'h0);
        check_eq("midrst_level", level, 0);
        check_eq("midrst_flags", {playing, overflow, prog_full, prog_empty}, 4'b0);
        check_eq("midrst_underrun", underrun_cnt, 0);
        sb.delete();
        model_level = 0;
        en = 1'b0;
        wait_cycles(3);
        rst = 1'b1;
        wait_cycles(2);

        // Audio-rate code: tick spacing of 2272 or 2273 cycles.
        code_clk_sample = 32'h001C_D5F9;
        for (int i = 0; i < 4; i++) begin
            send_frame(32'h7700_0000 + 32'(i));
        end
        p0 = pulses;
        en = 1'b1;
        wait_pulses(p0 + 3, 10000);
        check_eq("gap_a", (gap_a[p0 + 1] == 2272) || (gap_a[p0 + 1] == 2273), 1'b1);
        check_eq("gap_b", (gap_a[p0 + 2] == 2272) || (gap_a[p0 + 2] == 2273), 1'b1);
        wait_pulses(p0 + 4, 3000);
        check_eq("final_sb", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
